// File: rtl/tcp_rx_noc_in_if.sv
// Bundle of all flit/handshake signals around the TCP RX NoC deframer.
// slave = deframer side, master = NoC source plus downstream consumer.
interface tcp_rx_noc_in_if #(
    parameter int NOC_DATA_W = 256
);
    logic                  noc0_tcp_rx_in_val;
    logic [NOC_DATA_W-1:0] noc0_tcp_rx_in_data;
    logic                  tcp_rx_in_noc0_rdy;

    logic                  tcp_rx_in_dst_hdr_val;
    logic                  dst_tcp_rx_in_hdr_rdy;
    logic [NOC_DATA_W-1:0] tcp_rx_in_dst_hdr_flit;
    logic [NOC_DATA_W-1:0] tcp_rx_in_dst_meta_flit;

    logic                  tcp_rx_in_dst_data_val;
    logic                  dst_tcp_rx_in_data_rdy;
    logic [NOC_DATA_W-1:0] tcp_rx_in_dst_data;
    logic                  tcp_rx_in_dst_data_last;

    logic                  tcp_rx_in_len_err;

    modport slave (
        input  noc0_tcp_rx_in_val, noc0_tcp_rx_in_data,
               dst_tcp_rx_in_hdr_rdy, dst_tcp_rx_in_data_rdy,
        output tcp_rx_in_noc0_rdy, tcp_rx_in_dst_hdr_val,
               tcp_rx_in_dst_hdr_flit, tcp_rx_in_dst_meta_flit,
               tcp_rx_in_dst_data_val, tcp_rx_in_dst_data,
               tcp_rx_in_dst_data_last, tcp_rx_in_len_err
    );

    modport master (
        output noc0_tcp_rx_in_val, noc0_tcp_rx_in_data,
               dst_tcp_rx_in_hdr_rdy, dst_tcp_rx_in_data_rdy,
        input  tcp_rx_in_noc0_rdy, tcp_rx_in_dst_hdr_val,
               tcp_rx_in_dst_hdr_flit, tcp_rx_in_dst_meta_flit,
               tcp_rx_in_dst_data_val, tcp_rx_in_dst_data,
               tcp_rx_in_dst_data_last, tcp_rx_in_len_err
    );
endinterface

// File: rtl/tcp_rx_noc_in.sv
// TCP RX NoC deframer: header + meta flits are captured and issued as one bundle,
// then the remaining body flits stream straight through to the data consumer.
module tcp_rx_noc_in #(
    parameter int NOC_DATA_W = 256,
    parameter int LEN_W      = 8,
    parameter int LEN_LSB    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    tcp_rx_noc_in_if.slave      bus
);
    localparam logic [1:0] READY   = 2'd0;
    localparam logic [1:0] META_IN = 2'd1;
    localparam logic [1:0] HDR_OUT = 2'd2;
    localparam logic [1:0] DATA_IN = 2'd3;

    logic [1:0]            state;
    logic [LEN_W-1:0]      data_cnt;
    logic [LEN_W-1:0]      body_len;
    logic [NOC_DATA_W-1:0] hdr_reg;
    logic [NOC_DATA_W-1:0] meta_reg;

    logic noc_rdy;
    logic hdr_val;
    logic data_val;
    logic data_last;
    logic len_err;

    assign body_len = bus.noc0_tcp_rx_in_data[LEN_LSB +: LEN_W];

    // Handshake outputs are gated by rst_n so they read 0 throughout reset,
    // even though READY would otherwise advertise noc rdy.
    always_comb begin
        noc_rdy   = 1'b0;
        hdr_val   = 1'b0;
        data_val  = 1'b0;
        data_last = 1'b0;
        len_err   = 1'b0;
        if (rst_n) begin
            case (state)
                READY: begin
                    noc_rdy = 1'b1;
                    len_err = bus.noc0_tcp_rx_in_val && (body_len == '0);
                end
                META_IN: noc_rdy = 1'b1;
                HDR_OUT: hdr_val = 1'b1;
                DATA_IN: begin
                    noc_rdy   = bus.dst_tcp_rx_in_data_rdy;
                    data_val  = bus.noc0_tcp_rx_in_val;
                    data_last = (data_cnt == LEN_W'(1));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= READY;
            data_cnt <= '0;
            hdr_reg  <= '0;
            meta_reg <= '0;
        end else begin
            case (state)
                READY: begin
                    // zero-length headers are dropped in place
                    if (bus.noc0_tcp_rx_in_val && (body_len != '0)) begin
                        hdr_reg  <= bus.noc0_tcp_rx_in_data;
                        data_cnt <= body_len - LEN_W'(1);
                        state    <= META_IN;
                    end
                end
                META_IN: begin
                    if (bus.noc0_tcp_rx_in_val) begin
                        meta_reg <= bus.noc0_tcp_rx_in_data;
                        state    <= HDR_OUT;
                    end
                end
                HDR_OUT: begin
                    if (bus.dst_tcp_rx_in_hdr_rdy)
                        state <= (data_cnt == '0) ? READY : DATA_IN;
                end
                DATA_IN: begin
                    if (bus.noc0_tcp_rx_in_val && bus.dst_tcp_rx_in_data_rdy) begin
                        data_cnt <= data_cnt - LEN_W'(1);
                        if (data_cnt == LEN_W'(1))
                            state <= READY;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    assign bus.tcp_rx_in_noc0_rdy      = noc_rdy;
    assign bus.tcp_rx_in_dst_hdr_val   = hdr_val;
    assign bus.tcp_rx_in_dst_hdr_flit  = hdr_reg;
    assign bus.tcp_rx_in_dst_meta_flit = meta_reg;
    assign bus.tcp_rx_in_dst_data_val  = data_val;
    assign bus.tcp_rx_in_dst_data      = bus.noc0_tcp_rx_in_data;
    assign bus.tcp_rx_in_dst_data_last = data_last;
    assign bus.tcp_rx_in_len_err       = len_err;
endmodule

// File: tb/tb_tcp_rx_noc_in.sv
// Bench for tcp_rx_noc_in: directed corner cases plus randomized messages
// scored against a message-level model (bundle queue + data queue).
module tb_tcp_rx_noc_in;
    localparam int W  = 256;
    localparam int LW = 8;
    typedef logic [W-1:0] flit_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tcp_rx_noc_in_if #(.NOC_DATA_W(W)) bus ();

    tcp_rx_noc_in #(.NOC_DATA_W(W), .LEN_W(LW), .LEN_LSB(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input flit_t got, input flit_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state: flits to send, and what must come out
    flit_t fq[$];
    bit    hq[$];
    int    lq[$];
    flit_t ehq[$];
    flit_t emq[$];
    flit_t edq[$];
    bit    elq[$];
    int    exp_err = 0;

    function automatic flit_t rnd();
        flit_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic flit_t mk_hdr(input int len);
        flit_t h;
        h = rnd();
        h[LW-1:0] = LW'(len);
        return h;
    endfunction

    task automatic add_msg(input int len);
        flit_t h, m, d;
        h = mk_hdr(len);
        fq.push_back(h); hq.push_back(1'b1); lq.push_back(len);
        if (len == 0) begin
            exp_err++;
        end else begin
            m = rnd();
            fq.push_back(m); hq.push_back(1'b0);
            ehq.push_back(h); emq.push_back(m);
            for (int i = 1; i < len; i++) begin
                d = rnd();
                fq.push_back(d); hq.push_back(1'b0);
                edq.push_back(d); elq.push_back(i == len - 1);
            end
        end
    endtask

    // tight: no gaps and all ready, so header-to-header spacing is checked
    task automatic run(input bit tight, input int pgap, input int prdy);
        int cyc = 0;
        int last_hdr = -1;
        int last_len = 0;
        int err_seen = 0;
        int budget = 20000;
        while ((fq.size() != 0 || ehq.size() != 0 || edq.size() != 0) && cyc < budget) begin
            bus.noc0_tcp_rx_in_val    = (fq.size() != 0) && (tight || $urandom_range(99) >= pgap);
            bus.noc0_tcp_rx_in_data   = (fq.size() != 0) ? fq[0] : rnd();
            bus.dst_tcp_rx_in_hdr_rdy  = tight || ($urandom_range(99) < prdy);
            bus.dst_tcp_rx_in_data_rdy = tight || ($urandom_range(99) < prdy);
            @(negedge clk);
            chk("hdr_data_excl", flit_t'(bus.tcp_rx_in_dst_hdr_val & bus.tcp_rx_in_dst_data_val), '0);
            if (bus.tcp_rx_in_dst_hdr_val)
                chk("noc_rdy_in_hdr", flit_t'(bus.tcp_rx_in_noc0_rdy), '0);
            if (bus.tcp_rx_in_dst_hdr_val && bus.dst_tcp_rx_in_hdr_rdy) begin
                if (ehq.size() == 0) chk("spurious_hdr", 1, 0);
                else begin
                    chk("hdr_flit", bus.tcp_rx_in_dst_hdr_flit, ehq.pop_front());
                    chk("meta_flit", bus.tcp_rx_in_dst_meta_flit, emq.pop_front());
                end
            end
            if (bus.tcp_rx_in_dst_data_val && bus.dst_tcp_rx_in_data_rdy) begin
                if (edq.size() == 0) chk("spurious_data", 1, 0);
                else begin
                    chk("data", bus.tcp_rx_in_dst_data, edq.pop_front());
                    chk("last", flit_t'(bus.tcp_rx_in_dst_data_last), flit_t'(elq.pop_front()));
                end
            end
            if (bus.tcp_rx_in_len_err) err_seen++;
            if (bus.noc0_tcp_rx_in_val && bus.tcp_rx_in_noc0_rdy && fq.size() != 0) begin
                if (hq[0]) begin
                    if (tight && last_hdr >= 0)
                        chk("hdr_spacing", cyc - last_hdr, (last_len == 0) ? 1 : last_len + 2);
                    last_hdr = cyc;
                    last_len = lq.pop_front();
                end
                void'(fq.pop_front());
                void'(hq.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("drained", flit_t'(cyc < budget), 1);
        chk("len_err_count", err_seen, exp_err);
        exp_err = 0;
        bus.noc0_tcp_rx_in_val = 1'b0;
        bus.dst_tcp_rx_in_hdr_rdy = 1'b0;
        bus.dst_tcp_rx_in_data_rdy = 1'b0;
    endtask

    // present one flit until accepted (bounded)
    task automatic send(input flit_t f);
        bit ok = 1'b0;
        bus.noc0_tcp_rx_in_val = 1'b1;
        bus.noc0_tcp_rx_in_data = f;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.tcp_rx_in_noc0_rdy;
            @(posedge clk); #1;
        end
        chk("send_accepted", flit_t'(ok), 1);
        bus.noc0_tcp_rx_in_val = 1'b0;
    endtask

    initial begin
        flit_t h, m, d;
        bus.noc0_tcp_rx_in_val = 1'b0;
        bus.noc0_tcp_rx_in_data = '0;
        bus.dst_tcp_rx_in_hdr_rdy = 1'b0;
        bus.dst_tcp_rx_in_data_rdy = 1'b0;

        // reset: everything quiet, even with a zero-length header presented
        #12;
        bus.noc0_tcp_rx_in_val = 1'b1;
        bus.noc0_tcp_rx_in_data = mk_hdr(0);
        bus.dst_tcp_rx_in_hdr_rdy = 1'b1;
        bus.dst_tcp_rx_in_data_rdy = 1'b1;
        #1;
        chk("rst_noc_rdy", flit_t'(bus.tcp_rx_in_noc0_rdy), 0);
        chk("rst_hdr_val", flit_t'(bus.tcp_rx_in_dst_hdr_val), 0);
        chk("rst_data_val", flit_t'(bus.tcp_rx_in_dst_data_val), 0);
        chk("rst_last", flit_t'(bus.tcp_rx_in_dst_data_last), 0);
        chk("rst_len_err", flit_t'(bus.tcp_rx_in_len_err), 0);
        chk("rst_hdr_flit", bus.tcp_rx_in_dst_hdr_flit, 0);
        chk("rst_meta_flit", bus.tcp_rx_in_dst_meta_flit, 0);
        bus.noc0_tcp_rx_in_val = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back messages at full rate, incl. L=1 and L=0
        add_msg(3); add_msg(1); add_msg(1); add_msg(0); add_msg(2); add_msg(3);
        run(1'b1, 0, 100);

        // L=0 header: one-cycle len_err, no bundle, then normal L=2
        bus.noc0_tcp_rx_in_val = 1'b1;
        bus.noc0_tcp_rx_in_data = mk_hdr(0);
        bus.dst_tcp_rx_in_hdr_rdy = 1'b1;
        @(negedge clk);
        chk("len0_err", flit_t'(bus.tcp_rx_in_len_err), 1);
        chk("len0_rdy", flit_t'(bus.tcp_rx_in_noc0_rdy), 1);
        @(posedge clk); #1;
        bus.noc0_tcp_rx_in_val = 1'b0;
        @(negedge clk);
        chk("len0_err_clear", flit_t'(bus.tcp_rx_in_len_err), 0);
        chk("len0_no_hdr", flit_t'(bus.tcp_rx_in_dst_hdr_val), 0);
        @(posedge clk); #1;
        add_msg(2);
        run(1'b1, 0, 100);

        // bundle held 5 cycles by hdr_rdy=0; NoC stalled, nothing forwarded
        h = mk_hdr(2); m = rnd(); d = rnd();
        send(h); send(m);
        bus.dst_tcp_rx_in_data_rdy = 1'b1;
        bus.noc0_tcp_rx_in_val = 1'b1;
        bus.noc0_tcp_rx_in_data = d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_hdr_val", flit_t'(bus.tcp_rx_in_dst_hdr_val), 1);
            chk("hold_noc_rdy", flit_t'(bus.tcp_rx_in_noc0_rdy), 0);
            chk("hold_data_val", flit_t'(bus.tcp_rx_in_dst_data_val), 0);
            chk("hold_hdr_flit", bus.tcp_rx_in_dst_hdr_flit, h);
            chk("hold_meta_flit", bus.tcp_rx_in_dst_meta_flit, m);
            @(posedge clk); #1;
        end
        bus.dst_tcp_rx_in_hdr_rdy = 1'b1;
        @(posedge clk); #1;
        bus.dst_tcp_rx_in_hdr_rdy = 1'b0;
        @(negedge clk);
        chk("hold_data_out", bus.tcp_rx_in_dst_data, d);
        chk("hold_data_val2", flit_t'(bus.tcp_rx_in_dst_data_val), 1);
        chk("hold_data_last", flit_t'(bus.tcp_rx_in_dst_data_last), 1);
        @(posedge clk); #1;
        bus.noc0_tcp_rx_in_val = 1'b0;
        @(negedge clk);
        chk("hold_back_ready", flit_t'(bus.tcp_rx_in_noc0_rdy), 1);
        chk("hold_no_data", flit_t'(bus.tcp_rx_in_dst_data_val), 0);
        @(posedge clk); #1;

        // randomized gaps / backpressure, L=4 emphasised
        for (int i = 0; i < 6; i++) add_msg(4);
        run(1'b0, 40, 50);
        for (int i = 0; i < 40; i++) add_msg($urandom_range(0, 6));
        add_msg(20); add_msg(255);
        run(1'b0, 30, 60);
        for (int i = 0; i < 15; i++) add_msg($urandom_range(0, 5));
        run(1'b1, 0, 100);

        // reset in DATA_IN of an L=5 message after 2 data flits
        bus.dst_tcp_rx_in_hdr_rdy = 1'b1;
        send(mk_hdr(5)); send(rnd());
        @(negedge clk);
        chk("mid_hdr_val", flit_t'(bus.tcp_rx_in_dst_hdr_val), 1);
        @(posedge clk); #1;
        bus.dst_tcp_rx_in_hdr_rdy = 1'b0;
        bus.dst_tcp_rx_in_data_rdy = 1'b1;
        send(rnd()); send(rnd());
        bus.noc0_tcp_rx_in_val = 1'b1;
        bus.noc0_tcp_rx_in_data = rnd();
        #1;
        chk("mid_data_val", flit_t'(bus.tcp_rx_in_dst_data_val), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data_val", flit_t'(bus.tcp_rx_in_dst_data_val), 0);
        chk("mid_rst_noc_rdy", flit_t'(bus.tcp_rx_in_noc0_rdy), 0);
        chk("mid_rst_last", flit_t'(bus.tcp_rx_in_dst_data_last), 0);
        chk("mid_rst_hdr_val", flit_t'(bus.tcp_rx_in_dst_hdr_val), 0);
        chk("mid_rst_hdr_flit", bus.tcp_rx_in_dst_hdr_flit, 0);
        bus.noc0_tcp_rx_in_val = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", flit_t'(bus.tcp_rx_in_noc0_rdy), 1);
        @(posedge clk); #1;
        add_msg(2);
        run(1'b1, 0, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tcp_rx_noc_in.md
# tcp_rx_noc_in

Receive-side NoC deframer for the TCP tiles: accepts a NoC message (header flit, metadata flit, then zero or more data flits) from noc0, and splits it into a header/metadata bundle and a data-flit stream. It is the counterpart to the TX tile's NoC output controller, which emits messages in that header → meta → data order. A message's bundle is handed downstream before any of its data flits are forwarded.

## Interface
- NOC_DATA_W, 256, NoC flit width
- LEN_W, 8, width of the body-length field in the header flit
- LEN_LSB, 0, LSB position of the body-length field in the header flit
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- noc0_tcp_rx_in_val  in  1  NoC flit valid
- noc0_tcp_rx_in_data  in  NOC_DATA_W  NoC flit
- tcp_rx_in_noc0_rdy  out  1  NoC flit ready
- tcp_rx_in_dst_hdr_val  out  1  header/meta bundle valid
- dst_tcp_rx_in_hdr_rdy  in  1  bundle ready
- tcp_rx_in_dst_hdr_flit  out  NOC_DATA_W  captured header flit
- tcp_rx_in_dst_meta_flit  out  NOC_DATA_W  captured metadata flit
- tcp_rx_in_dst_data_val  out  1  data flit valid
- dst_tcp_rx_in_data_rdy  in  1  data flit ready
- tcp_rx_in_dst_data  out  NOC_DATA_W  data flit (noc0 data passed through)
- tcp_rx_in_dst_data_last  out  1  final data flit of message
- tcp_rx_in_len_err  out  1  one-cycle pulse: header had body length 0

## Operation
- Body length L = header[LEN_LSB +: LEN_W]; counts body flits (meta + data). Data flits = L-1.
- Registers: hdr_reg, meta_reg (NOC_DATA_W each), data_cnt (LEN_W), state.
- States:
  - READY: noc rdy=1. On noc val: if L==0, drop flit, pulse len_err, stay READY; else hdr_reg<=flit, data_cnt<=L-1, -> META_IN.
  - META_IN: noc rdy=1. On noc val: meta_reg<=flit, -> HDR_OUT.
  - HDR_OUT: noc rdy=0; hdr_val=1; bundle outputs = hdr_reg/meta_reg. On hdr_rdy: data_cnt==0 -> READY, else -> DATA_IN.
  - DATA_IN: data_val=noc val; noc rdy=data_rdy; data=noc data; last=(data_cnt==1). On val&rdy: data_cnt-=1; if last -> READY.
- hdr_flit/meta_flit outputs hold register contents in all states; downstream samples only in HDR_OUT.
- data_cnt never underflows: decrements only in DATA_IN with data_cnt≥1.
- L max 2^LEN_W-1; no wrap handling required beyond that.

## Timing
- Reset (rst_n=0, async): state=READY, data_cnt=0, hdr_reg=meta_reg=0; all val/rdy outputs, last and len_err forced 0 while rst_n=0.
- Header accepted cycle t; meta earliest t+1; hdr_val earliest t+2 (registered).
- Data path zero latency (combinational pass-through); one data flit per cycle at full throughput.
- Message of L body flits, no backpressure: L+2 cycles from header accept to return to READY (L-1 data, header, meta, one HDR_OUT cycle); next header accepted on the READY cycle.
- noc rdy never depends on noc val; data_val is never asserted outside DATA_IN.
- Reset mid-message: partial message discarded; READY on first edge after rst_n release.

## Test plan
- L=3 (meta + 2 data), all rdy=1: hdr_val 1 cycle with hdr/meta = sent flits; 2 data flits, last on second; back to READY.
- L=1: bundle issued, no data_val ever; next header accepted on the cycle after hdr_rdy handshake.
- hdr_rdy held 0 for 5 cycles in HDR_OUT: hdr_val stays 1, noc rdy stays 0, bundle stable, no data forwarded.
- L=4, data_rdy toggling 1/0 and noc val gaps: exactly 3 data flits out in order, last only on third, no flit lost/duplicated.
- Header with L=0: len_err pulses 1 cycle, no hdr_val, following valid message (L=2) handled normally.
- rst_n low during DATA_IN of L=5 after 2 data flits: all outputs 0 immediately; after release, new L=2 message processed correctly.
